// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
// Shared types for the reservation stations.
//   - Default geometry constants (RS depth, ROB tag width, operand width).
//   - ALU operation encoding carried through the ALU station.
//   - rs_slot_t: one reservation-station slot at the default widths.
// No ports (package).
// -----------------------------------------------------------------------------
package rv32i_types;

    localparam int RS_DEPTH_DEF = 4;
    localparam int ROB_W_DEF    = 3;
    localparam int XLEN_DEF     = 32;
    localparam int OP_W_DEF     = 4;

    typedef enum logic [OP_W_DEF-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [OP_W_DEF-1:0]  op;
        logic [ROB_W_DEF-1:0] rob_dest;
        logic                 wait1;
        logic [ROB_W_DEF-1:0] tag1;
        logic [XLEN_DEF-1:0]  q1;
        logic                 wait2;
        logic [ROB_W_DEF-1:0] tag2;
        logic [XLEN_DEF-1:0]  q2;
    } rs_slot_t;

endpackage

// File: rtl/rs_age_select.sv
// -----------------------------------------------------------------------------
// rs_age_select
// Oldest-ready grant and older-than matrix update for a reservation station.
// age[i][j] = 1 means slot j is older than slot i.
// Ports:
//   busy      in   N     registered busy vector
//   ready     in   N     candidate vector (subset of busy)
//   alloc     in   N     one-hot slot being written this cycle
//   alloc_en  in   1     alloc is valid
//   age       in   NxN   registered older-than matrix
//   grant     out  N     one-hot oldest ready slot (0 when none ready)
//   age_next  out  NxN   matrix value for the next cycle
// -----------------------------------------------------------------------------
module rs_age_select #(
    parameter int N = 4
) (
    input  logic [N-1:0]        busy,
    input  logic [N-1:0]        ready,
    input  logic [N-1:0]        alloc,
    input  logic                alloc_en,
    input  logic [N-1:0][N-1:0] age,
    output logic [N-1:0]        grant,
    output logic [N-1:0][N-1:0] age_next
);

    // A ready slot wins when no other ready slot is older than it. Stale bits
    // for freed slots are harmless because freed slots are never ready.
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = ready[i] & ~|(age[i] & ready);
        end
    end

    // New slot: every current resident is older (row = busy), and nobody is
    // older-than the newcomer's stale identity (column cleared).
    always_comb begin
        age_next = age;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (alloc_en && alloc[j]) begin
                    age_next[i][j] = 1'b0;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (alloc_en && alloc[i]) begin
                age_next[i] = busy;
            end
        end
    end

endmodule

// File: rtl/rs_alu_age.sv
// -----------------------------------------------------------------------------
// rs_alu_age
// ALU reservation station with oldest-first issue, multi-port CDB wakeup and
// pipeline flush.
// Optional feature macro: RS_CDB_BYPASS_EN -- when defined, a slot whose last
// waiting operand(s) match a valid CDB port is issue-ready in the same cycle
// and iss_qN is taken from the CDB.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    squash all slots; suppresses dispatch and issue
//   disp_*                   dispatch request (valid/ready) and slot contents
//   cdb_valid/rob/data       CDB_PORTS broadcast ports, port 0 in the LSBs
//   iss_valid/ready          issue handshake to the ALU
//   iss_op/q1/q2/rob_dest    fields of the presented entry
//   occupancy                registered busy slot count
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. disp_ready depends only on registered state; iss_valid never waits
// on iss_ready, and while iss_ready is low the presented entry may be
// replaced by an older one that became ready.
// -----------------------------------------------------------------------------
module rs_alu_age
    import rv32i_types::*;
#(
    parameter int RS_DEPTH  = RS_DEPTH_DEF,
    parameter int ROB_W     = ROB_W_DEF,
    parameter int XLEN      = XLEN_DEF,
    parameter int CDB_PORTS = 1,
    parameter int OP_W      = OP_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          disp_valid,
    output logic                          disp_ready,
    input  logic [OP_W-1:0]               disp_op,
    input  logic [ROB_W-1:0]              disp_rob_dest,
    input  logic                          disp_q1_wait,
    input  logic [ROB_W-1:0]              disp_q1_tag,
    input  logic [XLEN-1:0]               disp_q1_data,
    input  logic                          disp_q2_wait,
    input  logic [ROB_W-1:0]              disp_q2_tag,
    input  logic [XLEN-1:0]               disp_q2_data,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*ROB_W-1:0]    cdb_rob,
    input  logic [CDB_PORTS*XLEN-1:0]     cdb_data,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [OP_W-1:0]               iss_op,
    output logic [XLEN-1:0]               iss_q1,
    output logic [XLEN-1:0]               iss_q2,
    output logic [ROB_W-1:0]              iss_rob_dest,
    output logic [$clog2(RS_DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(RS_DEPTH + 1);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [ROB_W-1:0] rob_dest;
        logic             wait1;
        logic [ROB_W-1:0] tag1;
        logic [XLEN-1:0]  q1;
        logic             wait2;
        logic [ROB_W-1:0] tag2;
        logic [XLEN-1:0]  q2;
    } slot_t;

    slot_t                              slots [RS_DEPTH];
    slot_t                              new_slot;
    logic [RS_DEPTH-1:0]                busy, busy_next, ready, grant, alloc;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0]  age, age_next;
    logic [RS_DEPTH-1:0]                hit1, hit2;
    logic [XLEN-1:0]                    hdata1 [RS_DEPTH];
    logic [XLEN-1:0]                    hdata2 [RS_DEPTH];
    logic                               dhit1, dhit2;
    logic [XLEN-1:0]                    dhdata1, dhdata2;
    logic                               disp_fire, iss_fire;

    function automatic logic [OCC_W-1:0] popcount(input logic [RS_DEPTH-1:0] v);
        logic [OCC_W-1:0] c;
        c = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            c = c + OCC_W'(v[i]);
        end
        return c;
    endfunction

    // Tag match against every CDB port. Scanning from the highest port down
    // lets the lowest matching port overwrite last, so it wins.
    always_comb begin
        logic [ROB_W-1:0] ptag;
        logic [XLEN-1:0]  pdata;
        hit1 = '0;
        hit2 = '0;
        dhit1 = 1'b0;
        dhit2 = 1'b0;
        dhdata1 = '0;
        dhdata2 = '0;
        ptag = '0;
        pdata = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            hdata1[i] = '0;
            hdata2[i] = '0;
        end
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            ptag  = cdb_rob[p*ROB_W +: ROB_W];
            pdata = cdb_data[p*XLEN +: XLEN];
            if (cdb_valid[p]) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (slots[i].tag1 == ptag) begin
                        hit1[i]   = 1'b1;
                        hdata1[i] = pdata;
                    end
                    if (slots[i].tag2 == ptag) begin
                        hit2[i]   = 1'b1;
                        hdata2[i] = pdata;
                    end
                end
                if (disp_q1_tag == ptag) begin
                    dhit1   = 1'b1;
                    dhdata1 = pdata;
                end
                if (disp_q2_tag == ptag) begin
                    dhit2   = 1'b1;
                    dhdata2 = pdata;
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef RS_CDB_BYPASS_EN
            ready[i] = busy[i] & (~slots[i].wait1 | hit1[i]) & (~slots[i].wait2 | hit2[i]);
`else
            ready[i] = busy[i] & ~slots[i].wait1 & ~slots[i].wait2;
`endif
        end
    end

    // Lowest-index free slot, one-hot.
    always_comb begin
        alloc = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc    = '0;
                alloc[i] = 1'b1;
            end
        end
    end

    assign disp_ready = ~&busy;
    assign disp_fire  = disp_valid & disp_ready & ~flush;
    assign iss_valid  = (|grant) & ~flush;
    assign iss_fire   = iss_valid & iss_ready;

    rs_age_select #(.N(RS_DEPTH)) u_age (
        .busy     (busy),
        .ready    (ready),
        .alloc    (alloc),
        .alloc_en (disp_fire),
        .age      (age),
        .grant    (grant),
        .age_next (age_next)
    );

    // Dispatch-time capture: an operand produced on the CDB this very cycle
    // is stored as already resolved.
    always_comb begin
        new_slot.op       = disp_op;
        new_slot.rob_dest = disp_rob_dest;
        new_slot.tag1     = disp_q1_tag;
        new_slot.tag2     = disp_q2_tag;
        new_slot.wait1    = disp_q1_wait & ~dhit1;
        new_slot.wait2    = disp_q2_wait & ~dhit2;
        new_slot.q1       = (disp_q1_wait & dhit1) ? dhdata1 : disp_q1_data;
        new_slot.q2       = (disp_q2_wait & dhit2) ? dhdata2 : disp_q2_data;
    end

    always_comb begin
        iss_op       = '0;
        iss_rob_dest = '0;
        iss_q1       = '0;
        iss_q2       = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) begin
                iss_op       = slots[i].op;
                iss_rob_dest = slots[i].rob_dest;
`ifdef RS_CDB_BYPASS_EN
                iss_q1       = slots[i].wait1 ? hdata1[i] : slots[i].q1;
                iss_q2       = slots[i].wait2 ? hdata2[i] : slots[i].q2;
`else
                iss_q1       = slots[i].q1;
                iss_q2       = slots[i].q2;
`endif
            end
        end
    end

    always_comb begin
        if (flush) begin
            busy_next = '0;
        end else begin
            busy_next = (busy & ~(iss_fire ? grant : '0)) | (disp_fire ? alloc : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            age       <= '0;
            occupancy <= '0;
        end else begin
            busy      <= busy_next;
            occupancy <= popcount(busy_next);
            age       <= flush ? '0 : age_next;
            if (!flush) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (busy[i] && slots[i].wait1 && hit1[i]) begin
                        slots[i].wait1 <= 1'b0;
                        slots[i].q1    <= hdata1[i];
                    end
                    if (busy[i] && slots[i].wait2 && hit2[i]) begin
                        slots[i].wait2 <= 1'b0;
                        slots[i].q2    <= hdata2[i];
                    end
                    if (disp_fire && alloc[i]) begin
                        slots[i] <= new_slot;
                    end
                end
            end
        end
    end

endmodule
